// File: rtl/rr_logic_sched.sv
// rtl/rr_logic_sched.sv - round-robin scheduler sharing one registered f/g logic unit
// Keeps a private g context per requester; grants are bounded to MAX_BURST per owner.
module rr_logic_sched #(
    parameter int N_REQ     = 4,
    parameter int W         = 1,
    parameter int MAX_BURST = 2,
    localparam int IDW      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sched_en,
    input  logic                 ctx_clr,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   a_in,
    input  logic [N_REQ*W-1:0]   b_in,
    input  logic [N_REQ*W-1:0]   c_in,
    output logic [N_REQ-1:0]     gnt,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [W-1:0]         res_f,
    output logic [W-1:0]         res_g
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_B = CW'(MAX_BURST);

    logic             owner_vld;
    logic [IDW-1:0]   owner;
    logic [CW-1:0]    cnt;
    logic [W-1:0]     ctx [N_REQ];

    logic             gnt_any;
    logic             keep;
    logic [IDW-1:0]   gnt_id;
    logic             others;
    int               start;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [W-1:0]     sel_c;
    logic [W-1:0]     new_g;

    // Arbitration: keep the owner while within its burst (or it is alone),
    // otherwise scan forward from owner+1 with wrap.
    always_comb begin
        gnt_any = 1'b0;
        keep    = 1'b0;
        gnt_id  = '0;
        others  = |(req & ~(N_REQ'(1) << owner));
        start   = owner_vld ? int'(owner) + 1 : 0;
        if (!rst && sched_en && |req) begin
            if (owner_vld && req[owner] && (cnt < MAX_B || !others)) begin
                keep    = 1'b1;
                gnt_any = 1'b1;
                gnt_id  = owner;
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (!gnt_any && req[(start + k) % N_REQ]) begin
                        gnt_any = 1'b1;
                        gnt_id  = IDW'((start + k) % N_REQ);
                    end
                end
            end
        end
    end

    assign gnt   = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
    assign sel_a = a_in[int'(gnt_id)*W +: W];
    assign sel_b = b_in[int'(gnt_id)*W +: W];
    assign sel_c = c_in[int'(gnt_id)*W +: W];
    assign new_g = sel_b | sel_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_vld <= 1'b0;
            owner     <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_f     <= '0;
            res_g     <= '0;
        end else if (gnt_any) begin
            owner_vld <= 1'b1;
            owner     <= gnt_id;
            cnt       <= keep ? ((cnt == MAX_B) ? cnt : cnt + CW'(1)) : CW'(1);
            res_valid <= 1'b1;
            res_id    <= gnt_id;
            res_f     <= sel_a & ~ctx[gnt_id];
            res_g     <= new_g;
        end else begin
            cnt       <= '0;
            res_valid <= 1'b0;
        end
    end

    // Context update; a coincident clear wins over the granted requester's write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst || ctx_clr) begin
                ctx[i] <= '0;
            end else if (gnt_any && gnt_id == IDW'(i)) begin
                ctx[i] <= new_g;
            end
        end
    end

endmodule

// File: tb/tb_rr_logic_sched.sv
// tb/tb_rr_logic_sched.sv - self-checking bench for rr_logic_sched
// Directed scenarios followed by randomized traffic against a queue-free reference model.
module tb_rr_logic_sched;

    localparam int N  = 4;
    localparam int MB = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sched_en;
    logic       ctx_clr;
    logic [3:0] req;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] c_in;
    logic [3:0] gnt;
    logic       res_valid;
    logic [1:0] res_id;
    logic       res_f;
    logic       res_g;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit   m_vld;
    int   m_own;
    int   m_cnt;
    bit   m_ctx [N];
    bit   m_rv;
    int   m_rid;
    bit   m_rf;
    bit   m_rg;
    logic [3:0] obs_gnt;

    rr_logic_sched dut (
        .clk       (clk),
        .rst       (rst),
        .sched_en  (sched_en),
        .ctx_clr   (ctx_clr),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_f     (res_f),
        .res_g     (res_g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_vld = 0; m_own = 0; m_cnt = 0;
        m_rv = 0; m_rid = 0; m_rf = 0; m_rg = 0;
        for (int i = 0; i < N; i++) m_ctx[i] = 0;
    endtask

    function automatic int model_pick(input logic r, input logic en, input logic [3:0] rq);
        int base;
        if (r || !en || rq == 4'b0) return -1;
        if (m_vld && rq[m_own] && (m_cnt < MB || (rq & ~(4'b1 << m_own)) == 4'b0))
            return m_own;
        base = m_vld ? m_own : -1;
        for (int k = 1; k <= N; k++)
            if (rq[(base + k) % N]) return (base + k) % N;
        return -1;
    endfunction

    // One clock: drive at negedge, check gnt before the edge, check results after it.
    task automatic cyc(input logic r, input logic en, input logic clr, input logic [3:0] rq,
                       input logic [3:0] av, input logic [3:0] bv, input logic [3:0] cv);
        int p;
        @(negedge clk);
        rst = r; sched_en = en; ctx_clr = clr; req = rq;
        a_in = av; b_in = bv; c_in = cv;
        #1;
        p = model_pick(r, en, rq);
        obs_gnt = gnt;
        check("gnt", gnt, (p < 0) ? 4'b0 : (4'b1 << p));
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (p >= 0) begin
                m_cnt = (m_vld && p == m_own) ? ((m_cnt + 1 > MB) ? MB : m_cnt + 1) : 1;
                m_own = p;
                m_vld = 1;
                m_rv  = 1;
                m_rid = p;
                m_rf  = av[p] & ~m_ctx[p];
                m_rg  = bv[p] | cv[p];
                m_ctx[p] = m_rg;
            end else begin
                m_cnt = 0;
                m_rv  = 0;
            end
            if (clr) for (int i = 0; i < N; i++) m_ctx[i] = 0;
        end
        check("res_valid", res_valid, m_rv);
        check("res_id", res_id, m_rid);
        check("res_f", res_f, m_rf);
        check("res_g", res_g, m_rg);
    endtask

    int t2_ids [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        rst = 1; sched_en = 1; ctx_clr = 0; req = 0; a_in = 0; b_in = 0; c_in = 0;
        model_reset();

        // T1 reset with all requesting
        cyc(1, 1, 0, 4'b1111, 4'hF, 4'hF, 4'hF);
        cyc(1, 1, 0, 4'b1111, 4'hF, 4'hF, 4'hF);
        check("t1_gnt", obs_gnt, 4'b0);
        check("t1_outs", {res_valid, res_id, res_f, res_g}, 5'b0);

        // T2 burst rotation, first grant after reset is id 0
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, 0, 4'b1111, 4'h0, 4'h0, 4'h0);
            check("t2_seq", obs_gnt, 4'b1 << t2_ids[i]);
            check("t2_res_id", res_id, t2_ids[i]);
        end

        // T3 context isolation
        cyc(1, 1, 0, 4'b0000, 4'h0, 4'h0, 4'h0);
        cyc(0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        check("t3_f0", res_f, 1'b1);
        check("t3_g0", res_g, 1'b1);
        cyc(0, 1, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        check("t3_f1", res_f, 1'b1);
        cyc(0, 1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        check("t3_f0_ctx", res_f, 1'b0);

        // T4 sole requester then wrap
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 4'b1000, 4'h0, 4'h0, 4'h0);
            check("t4_sole", obs_gnt, 4'b1000);
        end
        cyc(0, 1, 0, 4'b1001, 4'b0001, 4'b0001, 4'b0000);
        check("t4_wrap", obs_gnt, 4'b0001);

        // T5 ctx_clr coincident with grant (ctx0 is 1 here)
        cyc(0, 1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        check("t5_f", res_f, 1'b0);
        check("t5_g", res_g, 1'b1);
        cyc(0, 1, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        check("t5_after", res_f, 1'b1);

        // T6 sched_en gap clears cnt, then reset pulse restarts at id 0
        cyc(0, 0, 0, 4'b1111, 4'h0, 4'h0, 4'h0);
        check("t6_en_gnt", obs_gnt, 4'b0);
        check("t6_en_valid", res_valid, 1'b0);
        cyc(0, 1, 0, 4'b1111, 4'h0, 4'h0, 4'h0);
        check("t6_keep_a", obs_gnt, 4'b0001);
        cyc(0, 1, 0, 4'b1111, 4'h0, 4'h0, 4'h0);
        check("t6_keep_b", obs_gnt, 4'b0001);
        cyc(0, 1, 0, 4'b1111, 4'h0, 4'h0, 4'h0);
        check("t6_switch", obs_gnt, 4'b0010);
        cyc(1, 1, 0, 4'b1111, 4'hF, 4'hF, 4'hF);
        check("t6_rst_valid", res_valid, 1'b0);
        cyc(0, 1, 0, 4'b1111, 4'h0, 4'h0, 4'h0);
        check("t6_restart", obs_gnt, 4'b0001);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
